mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the processor's single-port unified memory between two requesters:
  - instruction fetch (IF);
  - load/store unit (LS).
- Sits between the core pipeline and the memory inside the processor top.
- Serialises accesses, sequences the fixed-latency memory timing and returns read data / write acks to the owning requester.
- Load/store has priority; a streak limit prevents fetch starvation.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MEM_LAT, 1, memory read latency in cycles after mem_en (legal 1..4)
MAX_DATA_STREAK, 3, max consecutive LS grants while IF is waiting (legal 1..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held high with if_addr stable until if_gnt
if_addr  input  ADDR_W  fetch address
if_flush  input  1  discard response of in-flight fetch (branch redirect)
if_gnt  output  1  fetch request accepted this cycle
if_rdata  output  DATA_W  fetched instruction
if_rvalid  output  1  one-cycle pulse, if_rdata valid
ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata stable until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  data address
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  LS request accepted this cycle
ls_rdata  output  DATA_W  load data (0 for store ack)
ls_rvalid  output  1  one-cycle pulse: load data valid or store complete
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, streak=0, owner=IF, flush_pend=0, all outputs 0, in-flight access dropped, no rvalid produced.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - At most one outstanding transaction.
- IDLE:
  - if any req: choose winner, assert its gnt (combinational, this cycle only), latch addr/we/wdata/owner, go ISSUE.
  - no req: stay IDLE, gnts 0.
- Arbitration:
  - LS wins if ls_req, unless if_req && streak==MAX_DATA_STREAK, in which case IF wins.
  - streak increments on an LS grant made while if_req=1.
  - streak clears to 0 on any IF grant, and in IDLE when if_req=0.
  - streak saturates; never wraps.
- ISSUE (1 cycle): mem_en=1 with latched mem_we/mem_addr/mem_wdata. Go WAIT with cnt=MEM_LAT.
- WAIT:
  - mem_en=0; cnt decrements each cycle.
  - At cnt==1: register mem_rdata (loads/fetches) or 0 (stores) into the owner's rdata, set the owner's rvalid for the next cycle, go IDLE.
- Timing:
  - grant at cycle 0, mem_en at cycle 1, rvalid at cycle MEM_LAT+2.
  - new grant possible in the rvalid cycle.
  - period = MEM_LAT+2 cycles.
- rdata holds its last value between pulses; rvalid is never high for both requesters at once.
- mem_addr/mem_wdata/mem_we are held at latched values outside ISSUE; only mem_en qualifies them.
- Flush:
  - if_flush=1 while owner=IF and state in {ISSUE, WAIT} sets flush_pend; the memory access still completes but if_rvalid is suppressed.
  - flush_pend clears on return to IDLE.
  - if_flush in IDLE or during an LS transaction has no effect.
  - if_flush in the grant cycle itself does not cancel the grant.
- A requester dropping req before gnt withdraws with no side effect.
- req held high after gnt is a new request.

Decomposition:
- Shared package risc_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT);
  - owner encoding constants OWN_IF/OWN_LS;
  - default ADDR_W/DATA_W.
- No sub-module: the priority/streak logic is small and stays inline.

Test Plan:
- IF only, if_addr=0x0010, MEM_LAT=1, mem returns 0xA5A5 -> if_gnt at c0, mem_en/mem_addr=0x0010 at c1, if_rvalid=1 with if_rdata=0xA5A5 at c3, busy high c1-c2.
- Simultaneous if_req and ls_req (load 0x0200) -> ls_gnt first; if_gnt granted in LS's ls_rvalid cycle.
- LS continuously requesting with IF waiting, MAX_DATA_STREAK=3 -> grant order LS, LS, LS, IF, LS...; streak back to 0 after the IF grant.
- Store ls_we=1, addr 0x0300, data 0x1234 -> mem_we=1, mem_wdata=0x1234 in ISSUE; ls_rvalid pulse with ls_rdata=0; no if_rvalid.
- Fetch granted, if_flush pulsed during WAIT -> mem_en still issued, no if_rvalid; next fetch returns normally.
- rst asserted mid-WAIT -> outputs 0 immediately; no rvalid after release; next request completes with MEM_LAT+2 latency.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared processor package: memory arbiter state encoding, owner
// encoding and default bus widths.
package risc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Which requester owns the in-flight memory transaction
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Saturating increment of the load/store streak counter
  function automatic logic [2:0] streak_inc(input logic [2:0] cur, input logic [2:0] lim);
    if (cur < lim) begin
      return cur + 3'd1;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified memory between instruction fetch (IF)
// and the load/store unit (LS). One transaction outstanding at a time:
// IDLE (grant) -> ISSUE (mem_en) -> WAIT (MEM_LAT cycles) -> IDLE.
// LS has priority; after MAX_DATA_STREAK LS grants with IF waiting, IF wins.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   if_req/if_addr/if_flush        fetch request, address, redirect flush
//   if_gnt/if_rdata/if_rvalid      fetch accept, returned data, data pulse
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request
//   ls_gnt/ls_rdata/ls_rvalid      LS accept, load data (0 on store), pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory interface
//   busy                           high whenever not IDLE
module mem_port_arbiter
  import risc_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_r, state_s;
  logic [2:0]        cnt_r;
  logic [2:0]        streak_r, streak_s;
  logic              owner_r;
  logic              flush_pend_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] if_rdata_r, ls_rdata_r;
  logic              if_rvalid_r, ls_rvalid_r;
  logic              ls_win_s, if_win_s;
  logic              streak_full_s;
  logic              done_s;
  logic              flush_hit_s;
  logic              drop_if_s;

  assign streak_full_s = (streak_r == 3'(MAX_DATA_STREAK));
  assign done_s        = (state_r == WAIT) && (cnt_r == 3'd1);
  // A flush arriving in the final WAIT cycle must suppress the response too
  assign flush_hit_s   = if_flush && (owner_r == OWN_IF) &&
                         ((state_r == ISSUE) || (state_r == WAIT));
  assign drop_if_s     = flush_pend_r || flush_hit_s;

  // Grants are gated by reset so every output reads 0 while rst is high
  assign if_gnt    = if_win_s && !rst;
  assign ls_gnt    = ls_win_s && !rst;
  assign mem_en    = (state_r == ISSUE);
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign if_rvalid = if_rvalid_r;
  assign ls_rdata  = ls_rdata_r;
  assign ls_rvalid = ls_rvalid_r;
  assign busy      = (state_r != IDLE);

  // Next-state and winner selection
  always_comb begin
    state_s  = state_r;
    ls_win_s = 1'b0;
    if_win_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ls_req && !(if_req && streak_full_s)) begin
          ls_win_s = 1'b1;
          state_s  = ISSUE;
        end else if (if_req) begin
          if_win_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Streak of LS grants made while IF was waiting
  always_comb begin
    streak_s = streak_r;
    if (state_r == IDLE) begin
      if (if_win_s) begin
        streak_s = 3'd0;
      end else if (ls_win_s && if_req) begin
        streak_s = streak_inc(streak_r, 3'(MAX_DATA_STREAK));
      end else if (!if_req) begin
        streak_s = 3'd0;
      end else begin
        streak_s = streak_r;
      end
    end else begin
      streak_s = streak_r;
    end
  end

  // State, latency counter and streak registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 3'd0;
      streak_r <= 3'd0;
    end else begin
      state_r  <= state_s;
      streak_r <= streak_s;
      if (state_r == ISSUE) begin
        cnt_r <= 3'(MEM_LAT);
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Latch the winning request; memory bus holds these values until next grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r     <= OWN_IF;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if (ls_win_s) begin
      owner_r     <= OWN_LS;
      mem_we_r    <= ls_we;
      mem_addr_r  <= ls_addr;
      mem_wdata_r <= ls_wdata;
    end else if (if_win_s) begin
      owner_r     <= OWN_IF;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= if_addr;
    end
  end

  // Pending flush of the in-flight fetch, cleared on return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_r <= 1'b0;
    end else if (state_s == IDLE) begin
      flush_pend_r <= 1'b0;
    end else if (flush_hit_s) begin
      flush_pend_r <= 1'b1;
    end
  end

  // Response capture: one-cycle rvalid to the owner, rdata holds between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_r  <= {DATA_W{1'b0}};
      ls_rdata_r  <= {DATA_W{1'b0}};
      if_rvalid_r <= 1'b0;
      ls_rvalid_r <= 1'b0;
    end else begin
      if_rvalid_r <= 1'b0;
      ls_rvalid_r <= 1'b0;
      if (done_s) begin
        if (owner_r == OWN_LS) begin
          ls_rvalid_r <= 1'b1;
          ls_rdata_r  <= mem_we_r ? {DATA_W{1'b0}} : mem_rdata;
        end else if (!drop_if_s) begin
          if_rvalid_r <= 1'b1;
          if_rdata_r  <= mem_rdata;
        end
      end
    end
  end

endmodule
